// File: rtl/cam_dvp_pattern_gen_pkg.sv
// cam_dvp_pattern_gen_pkg: shared FSM states, pattern codes and RGB565 bar colours.
package cam_dvp_pattern_gen_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT} state_t;
  typedef enum logic [1:0] {PAT_BARS, PAT_RAMP, PAT_CNT, PAT_FRAME} pat_t;
  localparam logic [15:0] BAR_RGB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};
endpackage

// File: rtl/cam_dvp_pattern_gen_pattern.sv
// cam_dvp_pattern_gen_pattern: combinational RGB565 test-pattern byte selector.
module cam_dvp_pattern_gen_pattern
  import cam_dvp_pattern_gen_pkg::*;
#(
  parameter int H_PIXELS = 640
) (
  input  logic [1:0]  i_pat,
  input  logic [14:0] i_p,
  input  logic        i_b,
  input  logic [7:0]  i_byte_cnt,
  input  logic [7:0]  i_frame_id,
  output logic [7:0]  o_d
);
  logic [2:0]  w_bar;
  logic [15:0] w_rgb;
  assign w_bar = 3'(i_p / 15'(H_PIXELS / 8));
  assign w_rgb = BAR_RGB[w_bar];
  assign o_d = (i_pat == PAT_BARS) ? (i_b ? w_rgb[7:0] : w_rgb[15:8]) :
               (i_pat == PAT_RAMP) ? i_p[7:0] :
               (i_pat == PAT_CNT)  ? i_byte_cnt : i_frame_id;
endmodule

// File: rtl/cam_dvp_pattern_gen.sv
// cam_dvp_pattern_gen: OV7670-style DVP source (FSM, counters, PCLK); PCLK = MCLK/2.
// Define CAM_GEN_PCLK_GATE_EN to hold PCLK low outside HREF (plus one preamble period).
module cam_dvp_pattern_gen
  import cam_dvp_pattern_gen_pkg::*;
#(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       xipMCLK,
  input  logic       xinRESET,
  input  logic       xipEN,
  input  logic [1:0] xipPAT,
  output logic       xopCAM_PCLK,
  output logic       xopCAM_VSYNC,
  output logic       xopCAM_HREF,
  output logic [7:0] xopCAM_D,
  output logic       xopFRAME_DONE,
  output logic [7:0] xopFRAME_CNT
);
  localparam int LINE = 2 * H_PIXELS + H_BLANK;
  if (H_PIXELS % 8 != 0) begin : g_bad_h_pixels
    $error("cam_dvp_pattern_gen: H_PIXELS must be a multiple of 8");
  end
  state_t      r_state, w_next;
  logic        r_pclk, r_done;
  logic [15:0] r_h;
  logic [11:0] r_v, w_lines;
  logic [1:0]  r_pat;
  logic [7:0]  r_byte, r_fid, r_fcnt, w_pat_d;
  logic        w_line_end, w_last_line, w_state_end, w_fdone, w_vs_rise, w_href;
  assign w_lines = (r_state == ST_VBACK)  ? 12'(V_BACK) :
                   (r_state == ST_ACTIVE) ? 12'(V_LINES) :
                   (r_state == ST_VFRONT) ? 12'(V_FRONT) : 12'(VSYNC_LINES);
  assign w_line_end  = r_h == 16'(LINE - 1);
  assign w_last_line = r_v == w_lines - 12'd1;
  // r_pclk high means this MCLK edge is the PCLK falling edge where outputs may move
  assign w_state_end = r_pclk && w_line_end && w_last_line;
  assign w_fdone     = (r_state == ST_VFRONT) && w_state_end;
  assign w_vs_rise   = (w_next == ST_VSYNC) && (r_state != ST_VSYNC);
  assign w_href      = (r_state == ST_ACTIVE) && (r_h < 16'(2 * H_PIXELS));
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = (r_pclk && xipEN) ? ST_VSYNC : ST_IDLE;
      ST_VSYNC:  w_next = w_state_end ? ST_VBACK : ST_VSYNC;
      ST_VBACK:  w_next = w_state_end ? ST_ACTIVE : ST_VBACK;
      ST_ACTIVE: w_next = w_state_end ? ST_VFRONT : ST_ACTIVE;
      ST_VFRONT: w_next = !w_state_end ? ST_VFRONT : xipEN ? ST_VSYNC : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge xipMCLK or negedge xinRESET)
    if (!xinRESET) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_ff @(posedge xipMCLK or negedge xinRESET)
    if (!xinRESET) begin
      r_pclk <= 1'b0;
      r_done <= 1'b0;
      r_fcnt <= '0;
      r_h    <= '0;
      r_v    <= '0;
      r_pat  <= '0;
      r_fid  <= '0;
      r_byte <= '0;
    end else begin
      r_pclk <= !r_pclk;
      r_done <= w_fdone;
      r_fcnt <= r_fcnt + {7'd0, w_fdone};
      if (r_pclk) begin
        r_h <= (r_state == ST_IDLE || w_line_end) ? '0 : r_h + 16'd1;
        r_v <= (w_next != r_state) ? '0 : r_v + {11'd0, w_line_end};
      end
      // frame id takes the count including the frame completing on this same edge
      if (w_vs_rise) begin
        r_pat  <= xipPAT;
        r_fid  <= r_fcnt + {7'd0, w_fdone};
        r_byte <= '0;
      end else if (r_pclk && w_href) r_byte <= r_byte + 8'd1;
    end
  cam_dvp_pattern_gen_pattern #(.H_PIXELS(H_PIXELS)) u_pattern (
    .i_pat     (r_pat),
    .i_p       (r_h[15:1]),
    .i_b       (r_h[0]),
    .i_byte_cnt(r_byte),
    .i_frame_id(r_fid),
    .o_d       (w_pat_d)
  );
`ifdef CAM_GEN_PCLK_GATE_EN
  logic w_pre;
  assign w_pre = w_line_end && (((r_state == ST_VBACK) && w_last_line) ||
                                ((r_state == ST_ACTIVE) && !w_last_line));
  assign xopCAM_PCLK = r_pclk && (w_href || w_pre);
`else
  assign xopCAM_PCLK = r_pclk;
`endif
  assign xopCAM_VSYNC  = r_state == ST_VSYNC;
  assign xopCAM_HREF   = w_href;
  assign xopCAM_D      = w_href ? w_pat_d : 8'h00;
  assign xopFRAME_DONE = r_done;
  assign xopFRAME_CNT  = r_fcnt;
endmodule

// File: tb/tb_cam_dvp_pattern_gen.sv
// tb_cam_dvp_pattern_gen: frame-timeline model compared every MCLK, plus directed literal checks.
module tb_cam_dvp_pattern_gen;
  localparam int LN = 20, FR = 140;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [1:0] pat = 2'd0;
  logic pclk, vs, href, done;
  logic [7:0] d, fcnt;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [7:0] cap[$];
  logic [15:0] rgb [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [7:0] bars [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                            8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
  cam_dvp_pattern_gen #(.H_PIXELS(8), .V_LINES(4), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)) dut (
    .xipMCLK(clk), .xinRESET(rst_n), .xipEN(en), .xipPAT(pat),
    .xopCAM_PCLK(pclk), .xopCAM_VSYNC(vs), .xopCAM_HREF(href), .xopCAM_D(d),
    .xopFRAME_DONE(done), .xopFRAME_CNT(fcnt));
  always #5 clk = !clk;
  always @(posedge clk) cyc <= cyc + 1;
  // model: position m_f (PCLK index within the frame) plus per-frame latched settings
  bit m_pclk, m_run, m_done;
  int m_f, m_pat;
  logic [7:0] m_fid, m_fcnt, m_bytes;
  function automatic bit e_href();
    return m_run && (m_f / LN) >= 2 && (m_f / LN) < 6 && (m_f % LN) < 16;
  endfunction
  function automatic logic [7:0] e_d();
    int p, b;
    logic [15:0] c;
    p = (m_f % LN) / 2;
    b = (m_f % LN) % 2;
    c = rgb[p];
    if (!e_href()) return 8'h00;
    case (m_pat)
      0: return b ? c[7:0] : c[15:8];
      1: return 8'(p);
      2: return m_bytes;
      default: return m_fid;
    endcase
  endfunction
  function automatic bit e_pclk();
`ifdef CAM_GEN_PCLK_GATE_EN
    return m_pclk && (e_href() || (m_run && (m_f % LN) == LN - 1 && (m_f / LN) >= 1 && (m_f / LN) <= 4));
`else
    return m_pclk;
`endif
  endfunction
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      {m_pclk, m_run, m_done, m_f, m_pat, m_fid, m_fcnt, m_bytes} = '0;
    end else begin
      m_done = 1'b0;
      if (m_pclk) begin
        if (!m_run || m_f == FR - 1) begin
          if (m_run) begin m_fcnt = m_fcnt + 8'd1; m_done = 1'b1; end
          m_run = en;
          m_f = 0;
          if (en) begin m_pat = int'(pat); m_fid = m_fcnt; m_bytes = 8'd0; end
        end else begin
          if (e_href()) m_bytes = m_bytes + 8'd1;
          m_f = m_f + 1;
        end
      end
      m_pclk = !m_pclk;
    end
  end
  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask
  function automatic bit sig(int s);
    return s == 0 ? vs : s == 1 ? href : done;
  endfunction
  task automatic wait_for(input int s, input bit v, input int budget, input string nm, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig(s) == v) begin at = cyc; break; end
    end
    if (at < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout after %0d cycles, expected level %0d", nm, budget, v);
    end
  endtask
  int t0, t1, t2, t3, d1, d2, n, rises, vs_hi;
  bit prev;
  initial begin
    fork
      forever begin
        @(negedge clk);
        chk("m_pclk", pclk, e_pclk());
        chk("m_vsync", vs, m_run && m_f < LN);
        chk("m_href", href, e_href());
        chk("m_d", d, e_d());
        chk("m_done", done, m_done);
        chk("m_fcnt", fcnt, m_fcnt);
      end
      forever begin
        @(posedge pclk);
        if (href) cap.push_back(d);
      end
    join_none
    repeat (3) @(negedge clk);
    chk("rst_vsync", vs, 0);
    chk("rst_fcnt", fcnt, 0);
    en = 1'b1; pat = 2'd0; rst_n = 1'b1;
    // bars frame: timing and first line bytes
    wait_for(0, 1, 10, "vs_rise", t0);
    wait_for(0, 0, 60, "vs_fall", t1);
    chk("vs_width", t1 - t0, 40);
    wait_for(1, 1, 60, "href_rise", t2);
    chk("vback_len", t2 - t1, 40);
    wait_for(1, 0, 40, "href_fall", t3);
    chk("href_width", t3 - t2, 32);
    chk("bars_n", cap.size(), 16);
    for (int i = 0; i < 16; i++) chk("bars_byte", cap[i], bars[i]);
    pat = 2'd2;
    wait_for(2, 1, 300, "done1", d1);
    chk("fcnt1", fcnt, 1);
    @(negedge clk);
    chk("done_width", done, 0);
    cap.delete();
    // counter frame
    wait_for(2, 1, 300, "done2", d2);
    chk("done_gap", d2 - d1, 280);
    chk("fcnt2", fcnt, 2);
    chk("cnt_n", cap.size(), 64);
    for (int i = 0; i < 64; i++) chk("cnt_byte", cap[i], i);
    cap.delete();
    // second counter frame restarts at 0; pattern change mid-frame is deferred
    wait_for(1, 1, 300, "hrefC", t0);
    pat = 2'd3;
    wait_for(2, 1, 300, "done3", d1);
    chk("fcnt3", fcnt, 3);
    chk("cnt2_n", cap.size(), 64);
    chk("cnt2_first", cap[0], 0);
    chk("cnt2_last", cap[63], 63);
    cap.delete();
    // frame fill with count 3
    wait_for(1, 1, 300, "hrefD", t0);
    pat = 2'd1;
    wait_for(2, 1, 300, "done4", d1);
    chk("fcnt4", fcnt, 4);
    n = 0;
    foreach (cap[i]) if (cap[i] == 8'd3) n++;
    chk("fill_n", n, 64);
    cap.delete();
    // ramp frame, enable dropped mid-ACTIVE
    wait_for(1, 1, 300, "hrefE", t0);
    en = 1'b0;
    wait_for(2, 1, 300, "done5", d1);
    chk("fcnt5", fcnt, 5);
    chk("ramp_n", cap.size(), 64);
    for (int i = 0; i < 16; i++) chk("ramp_byte", cap[i], i / 2);
    prev = pclk; rises = 0; vs_hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pclk && !prev) rises++;
      if (vs) vs_hi++;
      prev = pclk;
    end
    chk("idle_vsync", vs_hi, 0);
`ifdef CAM_GEN_PCLK_GATE_EN
    chk("idle_pclk_rises", rises, 0);
`else
    chk("idle_pclk_rises", rises, 150);
`endif
    // async reset mid-line
    en = 1'b1; pat = 2'd0;
    wait_for(1, 1, 400, "hrefR", t0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pclk", pclk, 0);
    chk("arst_vsync", vs, 0);
    chk("arst_href", href, 0);
    chk("arst_d", d, 0);
    chk("arst_done", done, 0);
    chk("arst_fcnt", fcnt, 0);
    repeat (3) @(negedge clk);
    cap.delete();
    rst_n = 1'b1;
    wait_for(0, 1, 10, "vs_rise2", t0);
    wait_for(0, 0, 60, "vs_fall2", t1);
    chk("vs_width2", t1 - t0, 40);
    wait_for(2, 1, 300, "done6", d1);
    chk("fcnt_after_rst", fcnt, 1);
    chk("bars2_n", cap.size(), 64);
    for (int i = 0; i < 16; i++) chk("bars2_byte", cap[i], bars[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
